reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order Reorder Buffer (RoB) for the Tomasulo RISC-V core.
- Allocates one entry per issued instruction at the tail and hands that tail id to the reservation station / LSB as the result tag.
- Captures results from the common data bus (CDB), answers the two operand-lookup queries the reservation station makes at issue, and commits in order at the head.
- Commits update the register file, release stores to the LSB, and flush the pipeline on branch mispredict.

Parameters:
BITS, 4, log2 of entry count; id width.
SIZE, 16, entry count; must equal 2**BITS.

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous reset, active-low
rdy_in  in  1  ready; when low all state holds
issue_valid  in  1  allocate entry this cycle
issue_type  in  2  0=REG (writes rd), 1=BRANCH, 2=STORE; 3 treated as REG
issue_rd  in  5  destination register
issue_pred_taken  in  1  predictor decision (BRANCH only)
tail_id  out  BITS  id the next allocation will receive
full  out  1  count==SIZE
cdb_valid  in  1  result broadcast
cdb_id  in  BITS  RoB id of result
cdb_value  in  32  result value (BRANCH: correct next pc)
cdb_taken  in  1  actual branch outcome
query_id_1  in  BITS  operand lookup 1
query_busy_1  out  1  1 if value not yet available
query_value_1  out  32  value when query_busy_1=0
query_id_2, query_busy_2, query_value_2: same as port set 1
commit_valid  out  1  one-cycle commit pulse
commit_id  out  BITS  committed entry id
commit_rd  out  5  destination (0 for BRANCH/STORE)
commit_value  out  32  result value
commit_store  out  1  pulse: head STORE may write memory
flush  out  1  one-cycle mispredict pulse
flush_pc  out  32  redirect pc

Behaviour:
- Per-entry state: busy, ready, type, rd, value, pred_taken, taken. Pointers head and tail (BITS wide, wrap modulo SIZE) plus count (BITS+1 wide).
- Reset (rst_in=0 at posedge):
  - head=tail=count=0.
  - All busy/ready bits cleared.
  - All outputs 0: commit_valid, commit_store, flush, flush_pc, commit_id, commit_rd, commit_value.
  - Reset mid-operation discards every entry; no commit or flush pulse is produced.
- rdy_in=0: no state change; registered outputs hold their values.
- Issue: when issue_valid && !full at a posedge:
  - entry[tail] gets busy=1, ready=0, and type/rd/pred_taken.
  - tail increments (wraps SIZE-1 to 0).
  - issue_valid while full is ignored; the sender must gate on full.
- full is derived from registered count only. A commit in the same cycle does not free a slot for that cycle's issue.
- CDB: when cdb_valid && entry[cdb_id].busy, set value=cdb_value, taken=cdb_taken, ready=1. A CDB write to a non-busy id is ignored.
- Query (combinational, both ports independent):
  - If cdb_valid && cdb_id==query_id && entry busy: busy=0, value=cdb_value (bypass).
  - Else if entry ready or not busy: busy=0, value=entry.value.
  - Else busy=1, value=0.
- Commit: at a posedge with count>0 && entry[head].ready (ready registered, so a CDB write reaches commit no earlier than the next edge):
  - commit_valid=1 next cycle; commit_id=head; commit_value=value; commit_rd=rd for REG, else 0.
  - commit_store=1 for STORE.
  - entry busy=0; head increments.
  - At most one commit per cycle. commit_valid/commit_store/flush are cleared in every cycle with no commit.
- Mispredict: a committing BRANCH with taken != pred_taken:
  - flush=1 and flush_pc=value next cycle, alongside commit_valid=1.
  - On that same edge all entries are cleared, head=tail=0, count=0.
  - Any same-cycle issue is discarded; CDB writes that cycle are discarded.
- Count update: +1 on accepted issue, -1 on commit; both together leave count unchanged. Flush overrides to 0.
- Empty (count==0): no commit, even if a stale ready bit exists.

Test Plan:
- Reset, then 3 REG issues (rd=1,2,3) -> tail_id 0,1,2,3; CDB id1=0x22 then id0=0x11 -> commits id0 (rd1, 0x11) then id1 (rd2, 0x22) on consecutive cycles; id2 does not commit until its CDB arrives.
- 16 issues -> full=1; 17th issue ignored (tail_id stays 0). Commit id0 and issue in the same cycle -> issue accepted only next cycle; tail wraps to 1.
- Query id5 while busy -> busy=1. Same cycle cdb_id=5, value 0xDEAD -> busy=0, value 0xDEAD. Query id5 after -> 0xDEAD.
- BRANCH pred_taken=0, CDB taken=1, value 0x1000, followed by 2 REG entries -> at commit flush=1, flush_pc=0x1000, commit_rd=0; next cycle count=0, tail_id=0, full=0.
- STORE at head, CDB ready -> commit_store=1, commit_rd=0 for one cycle; BRANCH with correct prediction -> commit_valid=1, flush=0.
- rst_in=0 with 8 live entries and a pending CDB -> all outputs 0, tail_id=0; no commit after release.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at the tail, captures CDB
// results, answers two operand lookups, and retires one entry per cycle at
// the head. A mispredicted branch retires with a flush that empties the buffer.
module reorder_buffer #(
    parameter int BITS = 4,
    parameter int SIZE = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            issue_valid,
    input  logic [1:0]      issue_type,
    input  logic [4:0]      issue_rd,
    input  logic            issue_pred_taken,
    output logic [BITS-1:0] tail_id,
    output logic            full,
    input  logic            cdb_valid,
    input  logic [BITS-1:0] cdb_id,
    input  logic [31:0]     cdb_value,
    input  logic            cdb_taken,
    input  logic [BITS-1:0] query_id_1,
    output logic            query_busy_1,
    output logic [31:0]     query_value_1,
    input  logic [BITS-1:0] query_id_2,
    output logic            query_busy_2,
    output logic [31:0]     query_value_2,
    output logic            commit_valid,
    output logic [BITS-1:0] commit_id,
    output logic [4:0]      commit_rd,
    output logic [31:0]     commit_value,
    output logic            commit_store,
    output logic            flush,
    output logic [31:0]     flush_pc
);

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_STORE  = 2'd2,
        T_REG3   = 2'd3
    } rob_type_e;

    localparam logic [BITS:0] SIZE_C = (BITS+1)'(SIZE);

    // Per-entry state
    logic [SIZE-1:0] busy_q, busy_d;
    logic [SIZE-1:0] ready_q, ready_d;
    logic [SIZE-1:0] pred_q, pred_d;
    logic [SIZE-1:0] taken_q, taken_d;
    rob_type_e       type_q [SIZE];
    rob_type_e       type_d [SIZE];
    logic [4:0]      rd_q [SIZE];
    logic [4:0]      rd_d [SIZE];
    logic [31:0]     value_q [SIZE];
    logic [31:0]     value_d [SIZE];

    // Pointers and occupancy
    logic [BITS-1:0] head_q, head_d;
    logic [BITS-1:0] tail_q, tail_d;
    logic [BITS:0]   count_q, count_d;

    // Registered commit/flush outputs
    logic            commit_valid_q, commit_valid_d;
    logic [BITS-1:0] commit_id_q, commit_id_d;
    logic [4:0]      commit_rd_q, commit_rd_d;
    logic [31:0]     commit_value_q, commit_value_d;
    logic            commit_store_q, commit_store_d;
    logic            flush_q, flush_d;
    logic [31:0]     flush_pc_q, flush_pc_d;

    logic do_issue, do_commit, mispred;
    logic q1_hit, q2_hit;

    assign full     = (count_q == SIZE_C);
    assign tail_id  = tail_q;
    assign do_issue  = issue_valid && !full;
    // ready is registered, so a CDB result can retire no earlier than the next edge
    assign do_commit = (count_q != '0) && ready_q[head_q];
    assign mispred   = do_commit && (type_q[head_q] == T_BRANCH) &&
                       (taken_q[head_q] != pred_q[head_q]);

    // Operand lookups: same-cycle CDB bypass, else stored value once ready/retired
    assign q1_hit        = cdb_valid && (cdb_id == query_id_1) && busy_q[query_id_1];
    assign query_busy_1  = !q1_hit && busy_q[query_id_1] && !ready_q[query_id_1];
    assign query_value_1 = q1_hit ? cdb_value : (query_busy_1 ? 32'd0 : value_q[query_id_1]);
    assign q2_hit        = cdb_valid && (cdb_id == query_id_2) && busy_q[query_id_2];
    assign query_busy_2  = !q2_hit && busy_q[query_id_2] && !ready_q[query_id_2];
    assign query_value_2 = q2_hit ? cdb_value : (query_busy_2 ? 32'd0 : value_q[query_id_2]);

    assign commit_valid = commit_valid_q;
    assign commit_id    = commit_id_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_store = commit_store_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

    // Next state: CDB capture, tail allocation, head retirement, flush override
    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        pred_d         = pred_q;
        taken_d        = taken_q;
        type_d         = type_q;
        rd_d           = rd_q;
        value_d        = value_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_store_d = 1'b0;
        flush_d        = 1'b0;
        commit_id_d    = commit_id_q;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        flush_pc_d     = flush_pc_q;

        if (cdb_valid && busy_q[cdb_id]) begin
            value_d[cdb_id] = cdb_value;
            taken_d[cdb_id] = cdb_taken;
            ready_d[cdb_id] = 1'b1;
        end

        if (do_issue) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            type_d[tail_q]  = rob_type_e'(issue_type);
            rd_d[tail_q]    = issue_rd;
            pred_d[tail_q]  = issue_pred_taken;
            tail_d          = tail_q + 1'b1;
        end

        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
            commit_valid_d = 1'b1;
            commit_id_d    = head_q;
            commit_value_d = value_q[head_q];
            commit_rd_d    = (type_q[head_q] == T_BRANCH || type_q[head_q] == T_STORE)
                             ? 5'd0 : rd_q[head_q];
            commit_store_d = (type_q[head_q] == T_STORE);
        end

        case ({do_issue, do_commit})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Mispredict wipes every entry, including anything issued or written this cycle
        if (mispred) begin
            flush_d    = 1'b1;
            flush_pc_d = value_q[head_q];
            busy_d     = '0;
            ready_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    // State register with synchronous reset; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q         <= '0;
            ready_q        <= '0;
            pred_q         <= '0;
            taken_q        <= '0;
            for (int i = 0; i < SIZE; i++) begin
                type_q[i]  <= T_REG;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_store_q <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else if (rdy_in) begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            pred_q         <= pred_d;
            taken_q        <= taken_d;
            type_q         <= type_d;
            rd_q           <= rd_d;
            value_q        <= value_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_store_q <= commit_store_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed stimulus pushes expected
// commits; a negedge monitor pops and compares every commit pulse.
module tb_reorder_buffer;

    localparam int BITS = 4;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in;
    logic            issue_valid, issue_pred_taken;
    logic [1:0]      issue_type;
    logic [4:0]      issue_rd;
    logic [BITS-1:0] tail_id;
    logic            full;
    logic            cdb_valid, cdb_taken;
    logic [BITS-1:0] cdb_id;
    logic [31:0]     cdb_value;
    logic [BITS-1:0] query_id_1, query_id_2;
    logic            query_busy_1, query_busy_2;
    logic [31:0]     query_value_1, query_value_2;
    logic            commit_valid, commit_store, flush;
    logic [BITS-1:0] commit_id;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_value, flush_pc;

    reorder_buffer #(.BITS(4), .SIZE(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_taken(issue_pred_taken), .tail_id(tail_id), .full(full),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .query_id_1(query_id_1), .query_busy_1(query_busy_1), .query_value_1(query_value_1),
        .query_id_2(query_id_2), .query_busy_2(query_busy_2), .query_value_2(query_value_2),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_store(commit_store),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        st;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pt);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pred_taken = pt;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic tk);
        cdb_valid = 1'b1; cdb_id = id; cdb_value = v; cdb_taken = tk;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] v,
                        input logic st, input logic fl, input logic [31:0] pc);
        exp_t e;
        e.id = id; e.rd = rd; e.val = v; e.st = st; e.fl = fl; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " commit_valid"}, 32'(commit_valid), 32'd0);
        chk({tag, " commit_store"}, 32'(commit_store), 32'd0);
        chk({tag, " flush"},        32'(flush),        32'd0);
        chk({tag, " flush_pc"},     flush_pc,          32'd0);
        chk({tag, " commit_id"},    32'(commit_id),    32'd0);
        chk({tag, " commit_rd"},    32'(commit_rd),    32'd0);
        chk({tag, " commit_value"}, commit_value,      32'd0);
        chk({tag, " tail_id"},      32'(tail_id),      32'd0);
        chk({tag, " full"},         32'(full),         32'd0);
    endtask

    // Monitor: every commit pulse must match the head of the scoreboard
    always @(negedge clk_in) begin
        exp_t e;
        if (commit_valid) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_commit: got id %0d value %h, expected no commit",
                         commit_id, commit_value);
            end else begin
                e = sb.pop_front();
                chk("commit_id",    32'(commit_id),    32'(e.id));
                chk("commit_rd",    32'(commit_rd),    32'(e.rd));
                chk("commit_value", commit_value,      e.val);
                chk("commit_store", 32'(commit_store), 32'(e.st));
                chk("flush",        32'(flush),        32'(e.fl));
                if (e.fl) chk("flush_pc", flush_pc, e.pc);
            end
        end else if (commit_store || flush) begin
            n_vec++; n_err++;
            $display("FAIL stray_pulse: got store=%0b flush=%0b, expected 0 without commit",
                     commit_store, flush);
        end
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0; issue_pred_taken = 1'b0;
        cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0; cdb_taken = 1'b0;
        query_id_1 = '0; query_id_2 = '0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rst_in = 1'b1;

        // Out-of-order results retire in order; id2 waits for its result
        for (int i = 0; i < 3; i++) begin
            chk("tail_id_alloc", 32'(tail_id), 32'(i));
            issue(2'd0, 5'(i + 1), 1'b0);
        end
        chk("tail_id_after3", 32'(tail_id), 32'd3);
        cdb(4'd1, 32'h22, 1'b0);
        push(4'd0, 5'd1, 32'h11, 1'b0, 1'b0, 32'd0);
        push(4'd1, 5'd2, 32'h22, 1'b0, 1'b0, 32'd0);
        cdb(4'd0, 32'h11, 1'b0);
        repeat (5) tick();
        chk("sb_drained_t1", 32'(sb.size()), 32'd0);
        push(4'd2, 5'd3, 32'h33, 1'b0, 1'b0, 32'd0);
        cdb(4'd2, 32'h33, 1'b0);
        repeat (3) tick();
        rst_in = 1'b0; tick(); rst_in = 1'b1;

        // Fill to 16, overflow ignored, commit frees a slot only for the next cycle
        for (int i = 0; i < 16; i++) issue(2'd0, 5'(i + 1), 1'b0);
        chk("full_at16", 32'(full), 32'd1);
        chk("tail_wrap0", 32'(tail_id), 32'd0);
        issue(2'd0, 5'd31, 1'b0);
        chk("full_ovf_tail", 32'(tail_id), 32'd0);
        chk("full_ovf_full", 32'(full), 32'd1);
        push(4'd0, 5'd1, 32'h100, 1'b0, 1'b0, 32'd0);
        cdb(4'd0, 32'h100, 1'b0);
        issue(2'd0, 5'd20, 1'b0);
        chk("same_cycle_issue_tail", 32'(tail_id), 32'd0);
        chk("same_cycle_issue_full", 32'(full), 32'd0);
        issue(2'd0, 5'd20, 1'b0);
        chk("tail_wrap1", 32'(tail_id), 32'd1);
        rst_in = 1'b0; tick(); rst_in = 1'b1;

        // Operand lookups with CDB bypass
        for (int i = 0; i < 6; i++) issue(2'd0, 5'(10 + i), 1'b0);
        query_id_1 = 4'd5; #1;
        chk("q1_busy_pending", 32'(query_busy_1), 32'd1);
        chk("q1_value_pending", query_value_1, 32'd0);
        cdb_valid = 1'b1; cdb_id = 4'd5; cdb_value = 32'hDEAD; cdb_taken = 1'b0;
        query_id_2 = 4'd5; #1;
        chk("q2_bypass_busy", 32'(query_busy_2), 32'd0);
        chk("q2_bypass_value", query_value_2, 32'hDEAD);
        chk("q1_bypass_busy", 32'(query_busy_1), 32'd0);
        tick();
        cdb_valid = 1'b0; #1;
        chk("q1_after_busy", 32'(query_busy_1), 32'd0);
        chk("q1_after_value", query_value_1, 32'hDEAD);
        query_id_2 = 4'd4; #1;
        chk("q2_other_busy", 32'(query_busy_2), 32'd1);
        query_id_2 = 4'd9; #1;
        chk("q2_free_busy", 32'(query_busy_2), 32'd0);

        // Reset with 8 live entries and a pending result
        issue(2'd0, 5'd16, 1'b0);
        issue(2'd0, 5'd17, 1'b0);
        chk("tail_8live", 32'(tail_id), 32'd8);
        cdb_valid = 1'b1; cdb_id = 4'd0; cdb_value = 32'h77; rst_in = 1'b0;
        tick();
        cdb_valid = 1'b0; rst_in = 1'b1;
        chk_idle_outputs("midreset");
        repeat (4) tick();

        // Mispredicted branch flushes younger entries and same-cycle issue
        issue(2'd1, 5'd9, 1'b0);
        issue(2'd0, 5'd4, 1'b0);
        issue(2'd0, 5'd5, 1'b0);
        cdb(4'd1, 32'h55, 1'b0);
        push(4'd0, 5'd0, 32'h1000, 1'b0, 1'b1, 32'h1000);
        cdb(4'd0, 32'h1000, 1'b1);
        cdb_valid = 1'b1; cdb_id = 4'd2; cdb_value = 32'h66; cdb_taken = 1'b0;
        issue(2'd0, 5'd6, 1'b0);
        cdb_valid = 1'b0;
        chk("flush_tail", 32'(tail_id), 32'd0);
        chk("flush_full", 32'(full), 32'd0);
        repeat (4) tick();

        // Store release and correctly predicted branch
        issue(2'd2, 5'd7, 1'b0);
        issue(2'd1, 5'd8, 1'b1);
        push(4'd0, 5'd0, 32'hAB, 1'b1, 1'b0, 32'd0);
        cdb(4'd0, 32'hAB, 1'b0);
        push(4'd1, 5'd0, 32'h2000, 1'b0, 1'b0, 32'd0);
        cdb(4'd1, 32'h2000, 1'b1);
        repeat (3) tick();

        // rdy_in low freezes allocation and CDB capture
        issue(2'd0, 5'd1, 1'b0);
        chk("tail_pre_stall", 32'(tail_id), 32'd3);
        rdy_in = 1'b0; issue_valid = 1'b1;
        cdb_valid = 1'b1; cdb_id = 4'd2; cdb_value = 32'h5;
        tick();
        chk("tail_stall", 32'(tail_id), 32'd3);
        rdy_in = 1'b1; issue_valid = 1'b0; cdb_valid = 1'b0;
        repeat (3) tick();
        query_id_1 = 4'd2; #1;
        chk("stall_cdb_dropped", 32'(query_busy_1), 32'd1);

        chk("sb_drained_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
